// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, and redirect/stall/flush handling.
// Optional performance counters are enabled by defining IF_STAGE_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [15:0] stall_cnt,
  output logic [15:0] redirect_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{pc: 32'h0000_0000, instr: NOP_INSTR, valid: 1'b0};

  logic [31:0] pc, pc_next, pc_plus4;
  if_id_t      if_id, if_id_next;

  // Modulo-2^32 increment: the top word wraps to address zero.
  assign pc_plus4 = pc + 32'd4;

  // Priority: branch_taken > flush > stall > normal advance.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_next    = pc;
    if_id_next = if_id;
    if (branch_taken) begin
      pc_next    = {branch_target[31:2], 2'b00};
      if_id_next = BUBBLE;
    end else if (flush) begin
      if_id_next = BUBBLE;
      if (!stall) pc_next = pc_plus4;
    end else if (!stall) begin
      pc_next    = pc_plus4;
      if_id_next = '{pc: pc, instr: imem_rdata, valid: 1'b1};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      if_id <= BUBBLE;
    end else begin
      pc    <= pc_next;
      if_id <= if_id_next;
    end
  end

  assign imem_addr   = pc;
  assign pc_out      = pc;
  assign if_id_pc    = if_id.pc;
  assign if_id_instr = if_id.instr;
  assign if_id_valid = if_id.valid;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [15:0] stall_q, redirect_q;

  // Saturating event counters; a stall cycle overridden by a branch is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q    <= 16'h0000;
      redirect_q <= 16'h0000;
    end else begin
      if (stall && !branch_taken && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if ((branch_taken || flush) && redirect_q != 16'hFFFF)
        redirect_q <= redirect_q + 16'd1;
    end
  end

  assign stall_cnt    = stall_q;
  assign redirect_cnt = redirect_q;
`else
  assign stall_cnt    = 16'h0000;
  assign redirect_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; expectations track IF_STAGE_PERF_CNT_EN.
module tb_if_stage;

`ifdef IF_STAGE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_taken;
  logic [31:0] branch_target, imem_addr, imem_rdata, pc_out;
  logic [31:0] if_id_pc, if_id_instr;
  logic        if_id_valid;
  logic [15:0] stall_cnt, redirect_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word derived from its address.
  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = rd(imem_addr);

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_out(pc_out),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; branch_taken = 0; branch_target = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    branch_taken = 1; branch_target = t;
    step();
    branch_taken = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    #2 reset = 1;
    #1;
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_imem_addr got=%h exp=%h", imem_addr, 32'h0); end
    checks++; if (if_id_pc !== 32'h0) begin failures++; $display("FAIL reset_if_id_pc got=%h exp=%h", if_id_pc, 32'h0); end
    checks++; if (if_id_instr !== 32'h13) begin failures++; $display("FAIL reset_instr got=%h exp=%h", if_id_instr, 32'h13); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    checks++; if (stall_cnt !== 16'h0 || redirect_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h/%h exp=0/0", stall_cnt, redirect_cnt); end
    step();
    reset = 0;
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (if_id_pc !== 32'(i*4)) begin failures++; $display("FAIL seq_if_id_pc[%0d] got=%h exp=%h", i, if_id_pc, 32'(i*4)); end
      checks++; if (if_id_instr !== rd(32'(i*4))) begin failures++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, if_id_instr, rd(32'(i*4))); end
      checks++; if (if_id_valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, if_id_valid); end
      checks++; if (pc_out !== 32'(i*4+4)) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc_out, 32'(i*4+4)); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    redirect_to(32'hC);
    step();
    stall = 1;
    step();
    step();
    stall = 0;
    checks++; if (pc_out !== 32'h10) begin failures++; $display("FAIL stall_pc got=%h exp=%h", pc_out, 32'h10); end
    checks++; if (if_id_pc !== 32'hC || if_id_instr !== rd(32'hC) || if_id_valid !== 1'b1) begin failures++; $display("FAIL stall_if_id got=%h/%h/%b exp=%h/%h/1", if_id_pc, if_id_instr, if_id_valid, 32'hC, rd(32'hC)); end
    checks++; if (stall_cnt !== (PERF ? 16'd2 : 16'd0)) begin failures++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, PERF ? 2 : 0); end
    checks++; if (redirect_cnt !== (PERF ? 16'd1 : 16'd0)) begin failures++; $display("FAIL stall_redir_cnt got=%0d exp=%0d", redirect_cnt, PERF ? 1 : 0); end
  endtask

  task automatic test_branch_over_stall();
    do_reset();
    redirect_to(32'h20);
    stall = 1; flush = 1;
    redirect_to(32'h103);
    stall = 0; flush = 0;
    checks++; if (pc_out !== 32'h100) begin failures++; $display("FAIL br_pc got=%h exp=%h", pc_out, 32'h100); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || if_id_pc !== 32'h0) begin failures++; $display("FAIL br_bubble got=%h/%h/%b exp=0/13/0", if_id_pc, if_id_instr, if_id_valid); end
    checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL br_stall_cnt got=%0d exp=0", stall_cnt); end
    step();
    checks++; if (if_id_pc !== 32'h100 || if_id_instr !== rd(32'h100) || if_id_valid !== 1'b1) begin failures++; $display("FAIL br_target got=%h/%h/%b exp=%h/%h/1", if_id_pc, if_id_instr, if_id_valid, 32'h100, rd(32'h100)); end
    checks++; if (pc_out !== 32'h104) begin failures++; $display("FAIL br_pc_next got=%h exp=%h", pc_out, 32'h104); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_to(32'hFFFF_FFFF);
    checks++; if (pc_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_align got=%h exp=%h", pc_out, 32'hFFFF_FFFC); end
    step();
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", pc_out, 32'h0); end
    checks++; if (if_id_pc !== 32'hFFFF_FFFC || if_id_instr !== rd(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_if_id got=%h/%h exp=%h/%h", if_id_pc, if_id_instr, 32'hFFFF_FFFC, rd(32'hFFFF_FFFC)); end
  endtask

  task automatic test_flush();
    do_reset();
    step();
    flush = 1;
    step();
    flush = 0;
    checks++; if (pc_out !== 32'h8) begin failures++; $display("FAIL flush_pc got=%h exp=%h", pc_out, 32'h8); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || if_id_pc !== 32'h0) begin failures++; $display("FAIL flush_bubble got=%h/%h/%b exp=0/13/0", if_id_pc, if_id_instr, if_id_valid); end
    checks++; if (redirect_cnt !== (PERF ? 16'd1 : 16'd0)) begin failures++; $display("FAIL flush_redir_cnt got=%0d exp=%0d", redirect_cnt, PERF ? 1 : 0); end
  endtask

  task automatic test_stall_flush_reset();
    do_reset();
    redirect_to(32'h3C);
    step();
    stall = 1; flush = 1;
    step();
    flush = 0;
    checks++; if (pc_out !== 32'h40) begin failures++; $display("FAIL sf_pc got=%h exp=%h", pc_out, 32'h40); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin failures++; $display("FAIL sf_bubble got=%h/%b exp=13/0", if_id_instr, if_id_valid); end
    checks++; if (stall_cnt !== (PERF ? 16'd1 : 16'd0) || redirect_cnt !== (PERF ? 16'd2 : 16'd0)) begin failures++; $display("FAIL sf_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt, redirect_cnt, PERF ? 1 : 0, PERF ? 2 : 0); end
    branch_taken = 1; branch_target = 32'h200;
    #2 reset = 1;
    #1;
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL async_rst_pc got=%h exp=%h", pc_out, 32'h0); end
    checks++; if (stall_cnt !== 16'h0 || redirect_cnt !== 16'h0) begin failures++; $display("FAIL async_rst_cnt got=%0d/%0d exp=0/0", stall_cnt, redirect_cnt); end
    step();
    checks++; if (pc_out !== 32'h0 || if_id_valid !== 1'b0) begin failures++; $display("FAIL rst_hold got=%h/%b exp=0/0", pc_out, if_id_valid); end
    reset = 0;
    idle_inputs();
    step();
    checks++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1 || pc_out !== 32'h4) begin failures++; $display("FAIL rst_release got=%h/%b/%h exp=0/1/4", if_id_pc, if_id_valid, pc_out); end
  endtask

  task automatic test_saturation();
    do_reset();
    flush = 1;
`ifdef IF_STAGE_PERF_CNT_EN
    repeat (65535) @(posedge clk);
    #1;
    checks++; if (redirect_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_preset got=%h exp=FFFF", redirect_cnt); end
    step();
    checks++; if (redirect_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=FFFF", redirect_cnt); end
`else
    repeat (4) step();
    checks++; if (redirect_cnt !== 16'h0 || stall_cnt !== 16'h0) begin failures++; $display("FAIL cnt_tied got=%h/%h exp=0/0", redirect_cnt, stall_cnt); end
`endif
    flush = 0;
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_branch_over_stall();
    test_wrap();
    test_flush();
    test_stall_flush_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: bubble instruction (addi x0,x0,0) inserted on reset/flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit hold request; freezes PC and IF/ID.
REQ-006 flush  input  1  kill request for instruction in IF/ID.
REQ-007 branch_taken  input  1  redirect request from execute stage.
REQ-008 branch_target  input  32  redirect address.
REQ-009 imem_addr  output  32  instruction memory address, combinational equal to pc.
REQ-010 imem_rdata  input  32  instruction word, combinational read of imem_addr, same cycle.
REQ-011 pc_out  output  32  current fetch PC (debug/top-level observation).
REQ-012 if_id_pc  output  32  PC of instruction held in IF/ID.
REQ-013 if_id_instr  output  32  instruction held in IF/ID.
REQ-014 if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-015 stall_cnt  output  16  stall-cycle counter (see Configuration).
REQ-016 redirect_cnt  output  16  redirect/flush event counter (see Configuration).

Function
REQ-017 Normal cycle (no stall, flush, branch_taken): IF/ID <= {pc, imem_rdata, valid=1}; pc <= pc + 4.
REQ-018 PC arithmetic SHALL be 32-bit modulo: pc 32'hFFFF_FFFC advances to 32'h0000_0000, no error flag.
REQ-019 branch_taken=1: pc <= {branch_target[31:2],2'b00}; IF/ID <= {pc=0, NOP_INSTR, valid=0}; overrides stall and flush.
REQ-020 flush=1, branch_taken=0, stall=0: IF/ID <= bubble; pc <= pc + 4 (fetched word discarded).
REQ-021 stall=1, branch_taken=0, flush=0: pc and IF/ID hold all values unchanged.
REQ-022 stall=1 and flush=1, branch_taken=0: IF/ID <= bubble; pc holds.
REQ-023 Priority: branch_taken > flush > stall > normal advance.
REQ-024 Redirect latency: instruction at branch_target SHALL appear in IF/ID exactly one cycle after the branch_taken cycle, absent further stall/flush.
REQ-025 imem_addr and pc_out SHALL equal pc combinationally; low 2 bits always 0.
REQ-026 branch_target low 2 bits SHALL be ignored (force-aligned), no exception generated.

Reset
REQ-027 reset=1 SHALL asynchronously set pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, stall_cnt=0, redirect_cnt=0.
REQ-028 Reset asserted mid-operation SHALL override all inputs immediately, discarding any pending redirect.
REQ-029 First cycle after reset release SHALL fetch from RESET_PC; IF/ID valid one edge later.

Configuration
REQ-030 Macro IF_STAGE_PERF_CNT_EN defined: stall_cnt increments on each edge with stall=1 and branch_taken=0; redirect_cnt increments on each edge with branch_taken=1 or flush=1; both saturate at 16'hFFFF.
REQ-031 Macro IF_STAGE_PERF_CNT_EN undefined: no counter registers; stall_cnt and redirect_cnt tied to 16'h0000; all other behaviour identical.

Verification
REQ-032 Reset release, imem returns addr-derived words, 3 free cycles -> if_id_pc sequence 0x0,0x4,0x8, if_id_valid=1 from first edge.
REQ-033 pc=0x10, stall held 2 cycles -> pc stays 0x10, IF/ID unchanged, stall_cnt=2 (macro on) / 0 (macro off).
REQ-034 pc=0x20, branch_taken=1 with stall=1, target=0x103 -> next pc=0x100, if_id_valid=0, if_id_instr=0x00000013; following edge if_id_pc=0x100.
REQ-035 pc=0xFFFF_FFFC, free cycle -> pc=0x0000_0000, if_id_pc=0xFFFF_FFFC.
REQ-036 stall=1 and flush=1 at pc=0x40 -> pc=0x40, if_id_valid=0; reset pulsed mid-stall -> pc=RESET_PC immediately, counters 0.
REQ-037 Macro on, redirect_cnt preset near saturation via 65535 flushes, one more flush -> redirect_cnt stays 16'hFFFF.
